// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter.
// The width/zero-register macros are the project-wide defines; the package
// exposes them to SystemVerilog code along with the round-robin port type.

`ifndef RF_WB_DEFINES
`define RF_WB_DEFINES
`define WORD_WIDTH 32
`define REG_WIDTH 5
`define ZERO_REG 0
`endif

package rf_wb_arbiter_pkg;

    // Round-robin pointer value: which requester wins the next contested cycle.
    typedef enum logic {
        PICK_A = 1'b0,
        PICK_B = 1'b1
    } rr_port_e;

    // Architectural register that discards writes.
    localparam int ZERO_REG = `ZERO_REG;

endpackage

// File: rtl/rf_wb_rr_pick.sv
// Two-way round-robin grant for the write-back arbiter.
// Same destination on both ports forces B (the older load) to win, so
// program order is kept regardless of the pointer.

module rf_wb_rr_pick
    import rf_wb_arbiter_pkg::*;
#(
    parameter int REG_WIDTH = `REG_WIDTH
) (
    input  logic                 i_en,
    input  logic                 i_a_valid,
    input  logic                 i_b_valid,
    input  logic [REG_WIDTH-1:0] i_a_addr,
    input  logic [REG_WIDTH-1:0] i_b_addr,
    input  rr_port_e             i_ptr,
    output logic                 o_a_grant,
    output logic                 o_b_grant
);

    // Grant decision: nothing when disabled, otherwise the sole requester,
    // otherwise B on an address clash, otherwise the pointer's choice.
    always_comb begin
        o_a_grant = 1'b0;
        o_b_grant = 1'b0;
        if (i_en) begin
            if (i_a_valid && i_b_valid) begin
                if ((i_a_addr == i_b_addr) || (i_ptr == PICK_B)) begin
                    o_b_grant = 1'b1;
                end else begin
                    o_a_grant = 1'b1;
                end
            end else if (i_a_valid) begin
                o_a_grant = 1'b1;
            end else if (i_b_valid) begin
                o_b_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: merges the ALU (A) and load (B)
// write-back streams onto a single register-file write port with a
// one-cycle registered output and a saturating write counter.

module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH = `WORD_WIDTH,
    parameter int REG_WIDTH  = `REG_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  hold,
    input  logic                  a_valid,
    input  logic [REG_WIDTH-1:0]  a_addr,
    input  logic [WORD_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [REG_WIDTH-1:0]  b_addr,
    input  logic [WORD_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  RegWr,
    output logic [REG_WIDTH-1:0]  W_Reg,
    output logic [WORD_WIDTH-1:0] W_data,
    output logic [CNT_WIDTH-1:0]  wr_count
);

    rr_port_e              r_ptr;
    logic                  r_regwr;
    logic [REG_WIDTH-1:0]  r_wreg;
    logic [WORD_WIDTH-1:0] r_wdata;
    logic [CNT_WIDTH-1:0]  r_count;

    logic                  w_en;
    logic                  w_a_grant;
    logic                  w_b_grant;
    logic                  w_xfer;
    logic                  w_both;
    logic                  w_commit;
    logic [REG_WIDTH-1:0]  w_sel_addr;
    logic [WORD_WIDTH-1:0] w_sel_data;

    // Readies are suppressed during reset as well as during a stall.
    assign w_en = RST_n & ~hold;

    rf_wb_rr_pick #(
        .REG_WIDTH (REG_WIDTH)
    ) u_pick (
        .i_en      (w_en),
        .i_a_valid (a_valid),
        .i_b_valid (b_valid),
        .i_a_addr  (a_addr),
        .i_b_addr  (b_addr),
        .i_ptr     (r_ptr),
        .o_a_grant (w_a_grant),
        .o_b_grant (w_b_grant)
    );

    assign a_ready    = w_a_grant;
    assign b_ready    = w_b_grant;
    assign w_xfer     = w_a_grant | w_b_grant;
    assign w_both     = a_valid & b_valid;
    assign w_sel_addr = w_b_grant ? b_addr : a_addr;
    assign w_sel_data = w_b_grant ? b_data : a_data;
    // Writes to the zero register complete the handshake but are dropped here.
    assign w_commit   = w_xfer & (w_sel_addr != REG_WIDTH'(ZERO_REG));

    // Round-robin pointer: moves only after a contested transfer, to the loser.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_ptr <= PICK_A;
        end else if (w_xfer && w_both) begin
            r_ptr <= w_a_grant ? PICK_B : PICK_A;
        end
    end

    // Registered write port; address/data hold their value between transfers.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_regwr <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else begin
            r_regwr <= w_commit;
            if (w_xfer) begin
                r_wreg  <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
        end
    end

    // Saturating count of committed writes, advanced with the RegWr pulse it counts.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_count <= '0;
        end else if (w_commit && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign RegWr    = r_regwr;
    assign W_Reg    = r_wreg;
    assign W_data   = r_wdata;
    assign wr_count = r_count;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by
// randomized traffic compared against a behavioural model.

module tb_rf_wb_arbiter;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        CLK;
    logic        RST_n;
    logic        hold;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        RegWr;
    logic [4:0]  W_Reg;
    logic [31:0] W_data;
    logic [CNT_W-1:0] wr_count;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    int          m_ptr;      // 0: A preferred on contest, 1: B preferred
    bit          m_regwr;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    int          m_cnt;

    bit obs_ga, obs_gb;     // readies observed before the last edge
    bit last_ga, last_gb;   // model grants for the last edge

    rf_wb_arbiter #(
        .CNT_WIDTH (CNT_W)
    ) dut (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .hold     (hold),
        .a_valid  (a_valid),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .RegWr    (RegWr),
        .W_Reg    (W_Reg),
        .W_data   (W_data),
        .wr_count (wr_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                         input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                         input bit h);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        hold    = h;
    endtask

    // One clock cycle: check readies, advance the model at the edge, check outputs.
    task automatic cycle();
        bit ga, gb, rs, av, bv;
        logic [4:0]  aa, ba;
        logic [31:0] ad, bd;
        #1;
        rs = RST_n; av = a_valid; bv = b_valid;
        aa = a_addr; ba = b_addr; ad = a_data; bd = b_data;
        ga = 0; gb = 0;
        if (rs && !hold) begin
            if (av && bv) begin
                if (aa == ba) gb = 1;          // older load first
                else if (m_ptr == 0) ga = 1;
                else gb = 1;
            end else if (av) ga = 1;
            else if (bv) gb = 1;
        end
        chk("a_ready", a_ready, ga);
        chk("b_ready", b_ready, gb);
        obs_ga = a_ready; obs_gb = b_ready;
        last_ga = ga; last_gb = gb;
        @(posedge CLK);
        if (!rs) begin
            m_regwr = 0; m_wreg = 0; m_wdata = 0; m_cnt = 0; m_ptr = 0;
        end else begin
            m_regwr = 0;
            if (ga || gb) begin
                m_wreg  = ga ? aa : ba;
                m_wdata = ga ? ad : bd;
                m_regwr = (m_wreg != 0);
                if (m_regwr && m_cnt < CNT_MAX) m_cnt++;
                if (av && bv) m_ptr = ga ? 1 : 0;
            end
        end
        #1;
        chk("RegWr", RegWr, m_regwr);
        chk("W_Reg", W_Reg, m_wreg);
        chk("W_data", W_data, m_wdata);
        chk("wr_count", wr_count, m_cnt);
        @(negedge CLK);
    endtask

    initial begin
        bit pa, pb;
        RST_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        m_ptr = 0; m_regwr = 0; m_wreg = 0; m_wdata = 0; m_cnt = 0;
        @(negedge CLK);

        // reset
        cycle(); cycle();
        chk("rst_regwr", RegWr, 0);
        chk("rst_wreg", W_Reg, 0);
        chk("rst_wdata", W_data, 0);
        chk("rst_cnt", wr_count, 0);
        RST_n = 1'b1;

        // single A write
        drive(1, 5, 32'h1234_5678, 0, 0, 0, 0);
        cycle();
        chk("single_ardy", obs_ga, 1);
        chk("single_regwr", RegWr, 1);
        chk("single_wreg", W_Reg, 5);
        chk("single_wdata", W_data, 32'h1234_5678);
        chk("single_cnt", wr_count, 1);

        // contested, different addresses: A,B,A,B
        for (int k = 0; k < 4; k++) begin
            drive(1, 3, 32'hA0 + k, 1, 4, 32'hB0 + k, 0);
            cycle();
            chk("alt_ga", obs_ga, (k % 2) == 0);
            chk("alt_gb", obs_gb, (k % 2) == 1);
            chk("alt_regwr", RegWr, 1);
        end
        chk("alt_cnt", wr_count, 5);

        // contested, same address: B first, then A
        drive(1, 7, 32'hAAAA_0001, 1, 7, 32'hBBBB_0002, 0);
        cycle();
        chk("same_gb", obs_gb, 1);
        chk("same_wreg1", W_Reg, 7);
        chk("same_wdata1", W_data, 32'hBBBB_0002);
        drive(1, 7, 32'hAAAA_0001, 0, 0, 0, 0);
        cycle();
        chk("same_ga", obs_ga, 1);
        chk("same_wreg2", W_Reg, 7);
        chk("same_wdata2", W_data, 32'hAAAA_0001);

        // write to zero register
        drive(1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        cycle();
        chk("zero_ardy", obs_ga, 1);
        chk("zero_regwr", RegWr, 0);
        chk("zero_cnt", wr_count, 7);

        // hold for three cycles, then release
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 32'hC1, 1, 2, 32'hC2, 1);
            cycle();
            chk("hold_ga", obs_ga, 0);
            chk("hold_gb", obs_gb, 0);
            chk("hold_regwr", RegWr, 0);
        end
        drive(1, 1, 32'hC1, 1, 2, 32'hC2, 0);
        cycle();
        chk("rel_ga", obs_ga, 1);
        chk("rel_wreg", W_Reg, 1);
        drive(0, 0, 0, 1, 2, 32'hC2, 0);
        cycle();
        chk("rel_gb", obs_gb, 1);
        chk("rel_cnt", wr_count, 9);

        // reset right after a grant, with pointer left at B
        drive(1, 9, 32'h99, 1, 11, 32'h11, 0);
        cycle();
        chk("pre_gb", obs_gb, 1);
        drive(1, 9, 32'h99, 1, 12, 32'h12, 0);
        cycle();
        chk("pre_ga", obs_ga, 1);
        RST_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("rst2_regwr", RegWr, 0);
        chk("rst2_cnt", wr_count, 0);
        RST_n = 1'b1;
        cycle();
        chk("rst2_nopulse", RegWr, 0);
        drive(1, 13, 32'h13, 1, 14, 32'h14, 0);
        cycle();
        chk("rst2_ptr_a", obs_ga, 1);

        // randomized traffic against the model
        pa = 0; pb = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            if (!pa && $urandom_range(0, 2) != 0) begin
                pa = 1;
                a_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                a_data = $urandom;
            end
            if (!pb && $urandom_range(0, 2) != 0) begin
                pb = 1;
                b_addr = (pa && $urandom_range(0, 2) == 0) ? a_addr : 5'($urandom);
                b_data = $urandom;
            end
            a_valid = pa;
            b_valid = pb;
            hold    = ($urandom_range(0, 4) == 0);
            RST_n   = !(i > 100 && $urandom_range(0, 99) == 0);
            cycle();
            if (last_ga) pa = 0;
            if (last_gb) pb = 0;
        end

        // saturation of the write counter
        RST_n = 1'b1;
        for (int k = 0; k < CNT_MAX + 5; k++) begin
            drive(1, 1, 32'(k), 0, 0, 0, 0);
            cycle();
        end
        chk("sat_cnt", wr_count, CNT_MAX);
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter WORD_WIDTH, default `WORD_WIDTH (32): data width of write-back words.
REQ-002 Parameter REG_WIDTH, default `REG_WIDTH (5): register-address width.
REQ-003 Parameter CNT_WIDTH, default 16: width of the write-statistics counter.
REQ-004 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 RST_n  in  1  reset, synchronous, active-low.
REQ-006 hold  in  1  pipeline stall from the control unit; when high, no request is granted.
REQ-007 a_valid  in  1  ALU write-back request.
REQ-008 a_addr  in  REG_WIDTH  ALU destination register.
REQ-009 a_data  in  WORD_WIDTH  ALU result.
REQ-010 a_ready  out  1  ALU request granted this cycle.
REQ-011 b_valid, b_addr, b_data, b_ready: same meanings, for the load/memory write-back requester.
REQ-012 RegWr  out  1  register-file write enable.
REQ-013 W_Reg  out  REG_WIDTH  register-file write address.
REQ-014 W_data  out  WORD_WIDTH  register-file write data.
REQ-015 wr_count  out  CNT_WIDTH  saturating count of committed non-zero-register writes.

Function
REQ-016 A transfer occurs on port X when X_valid && X_ready at a rising edge; X_ready is combinational from the valids, the addresses, hold and the priority pointer.
REQ-017 At most one of a_ready and b_ready is high in any cycle; both are low whenever hold=1.
REQ-018 A ready is never high while its own valid is low.
REQ-019 Only one requester valid and hold=0: that requester is granted.
REQ-020 Both valid, addresses differ, hold=0: the port selected by the 1-bit round-robin pointer (0=A, 1=B) is granted.
REQ-021 Both valid, addresses equal, hold=0: B is granted regardless of the pointer, so that program order is kept (the load is older); A is granted on a later cycle.
REQ-022 The pointer updates only on a transfer made while both requesters were valid, and then points to the port not granted; a single-requester grant leaves it unchanged.
REQ-023 Latency 1: for a transfer at edge t, RegWr, W_Reg and W_data are driven from registers during cycle t+1.
REQ-024 In any cycle with no transfer at the previous edge, RegWr=0 and W_Reg/W_data hold their last values.
REQ-025 A transfer to register 0 completes the handshake but leaves RegWr=0 and wr_count unchanged.
REQ-026 wr_count increments by 1 each cycle in which RegWr=1 and saturates at all-ones.
REQ-027 Requesters hold valid, addr and data stable until they are granted; the block does not buffer requests that are not granted.

Reset
REQ-028 While RST_n=0 at an edge: RegWr=0, W_Reg=0, W_data=0, wr_count=0, pointer=0 (A first).
REQ-029 a_ready=0 and b_ready=0 throughout any cycle in which RST_n=0.
REQ-030 A transfer pending in the output register when reset asserts is discarded, and no RegWr pulse follows reset release.

Structure
REQ-031 WORD_WIDTH, REG_WIDTH and the zero-register constant come from the shared defines file; no local redefinition.
REQ-032 A single sub-module, rf_wb_rr_pick, performs the 2-way round-robin grant with the same-address override; all registers live in the top level.

Verification
REQ-033 Only A valid, addr=5, data=0x1234_5678 -> a_ready=1 at that edge; next cycle RegWr=1, W_Reg=5, W_data=0x1234_5678; wr_count=1.
REQ-034 A and B valid continuously, addrs 3/4, pointer=0 -> grants alternate A,B,A,B; RegWr high on four consecutive cycles.
REQ-035 A and B both valid with addr=7, pointer=0 -> B is granted first and A the next cycle; W_Reg=7 on both cycles, and the final W_data is A's data.
REQ-036 A valid, addr=0 -> a_ready=1; next cycle RegWr=0; wr_count unchanged.
REQ-037 hold=1 for 3 cycles with both valid -> both readies low and RegWr=0; after release -> grants resume, honouring the pointer.
REQ-038 RST_n low for one edge in the cycle after a grant -> RegWr=0, wr_count=0, pointer=0; the discarded write never reaches the register file.
